// File: rtl/seg7_pkg.sv
// Shared constants for seven-segment display blocks.
// Segment vectors are ordered {g,f,e,d,c,b,a} and are active-low:
// a 0 bit lights the segment.
package seg7_pkg;

  // All segments dark.
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Hex glyphs, 0-F. Letters b and d use the lowercase shapes so they
  // cannot be confused with 8 and 0.
  localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
  localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
  localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
  localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
  localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
  localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
  localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
  localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
  localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
  localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
  localparam logic [6:0] SEG_HEX_A = 7'b0001000;
  localparam logic [6:0] SEG_HEX_B = 7'b0000011;
  localparam logic [6:0] SEG_HEX_C = 7'b1000110;
  localparam logic [6:0] SEG_HEX_D = 7'b0100001;
  localparam logic [6:0] SEG_HEX_E = 7'b0000110;
  localparam logic [6:0] SEG_HEX_F = 7'b0001110;

  // Lookup table indexed directly by the nibble value (entry 0 is the
  // rightmost element of the concatenation).
  localparam logic [15:0][6:0] SEG_HEX_TABLE = {
    SEG_HEX_F, SEG_HEX_E, SEG_HEX_D, SEG_HEX_C,
    SEG_HEX_B, SEG_HEX_A, SEG_HEX_9, SEG_HEX_8,
    SEG_HEX_7, SEG_HEX_6, SEG_HEX_5, SEG_HEX_4,
    SEG_HEX_3, SEG_HEX_2, SEG_HEX_1, SEG_HEX_0
  };

  // Bits needed to hold values 0..n-1, never less than one bit so that
  // degenerate parameterisations (n = 1) still produce a legal vector.
  function automatic int clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) begin
        w = i + 1;
      end
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seg7_scan_hex7_dec.sv
// hex7_dec: nibble to active-low seven-segment glyph, purely combinational.
// Shared by every display block that shows hex digits.
module hex7_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  // Table lookup; every nibble value has a glyph so there is no default.
  always_comb begin
    seg_n = SEG_HEX_TABLE[nibble];
  end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for a common-anode seven-segment
// display. The divided clock tick_in is sampled as a plain signal in the
// clk domain and its rising edges pace the scan: SCAN_DIV edges per digit
// slot, digits visited 0,1,..,DIGITS-1,0. The displayed number is latched
// once per frame so a value changing mid-scan never shows a torn mixture
// of old and new digits.
//
// Build option: define SEG7_SCAN_LZB_EN to enable leading-zero blanking
// (upper digits whose nibble and every nibble above it are zero stay dark,
// unless that digit's decimal point is requested). Without the macro all
// digits are always lit.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_in,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int CW = clog2(SCAN_DIV);
  localparam int DW = clog2(DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIG_LAST = DW'(DIGITS - 1);

  // Registered state
  logic                tick_q,      tick_d;
  logic [CW-1:0]       scan_cnt_q,  scan_cnt_d;
  logic [DW-1:0]       digit_q,     digit_d;
  logic [4*DIGITS-1:0] frame_val_q, frame_val_d;
  logic [DIGITS-1:0]   frame_dp_q,  frame_dp_d;
  logic                load_q,      load_d;
  logic [DIGITS-1:0]   an_q,        an_d;
  logic [6:0]          seg_q,       seg_d;
  logic                dp_q,        dp_d;

  // Scan control
  logic                tick_edge;
  logic                slot_done;
  logic                frame_wrap;

  // Currently selected digit data
  logic [3:0]          cur_nibble;
  logic                cur_dp;
  logic [6:0]          cur_seg;

  // Rising-edge detect on tick_in and slot/digit advance.
  always_comb begin
    tick_d     = tick_in;
    tick_edge  = tick_in & ~tick_q;
    slot_done  = tick_edge && (scan_cnt_q == CNT_LAST);
    frame_wrap = slot_done && (digit_q == DIG_LAST);
    scan_cnt_d = scan_cnt_q;
    digit_d    = digit_q;
    if (tick_edge) begin
      scan_cnt_d = slot_done ? '0 : scan_cnt_q + 1'b1;
    end
    if (slot_done) begin
      digit_d = frame_wrap ? '0 : digit_q + 1'b1;
    end
  end

  // Frame latch: capture value/dp_in when the scan returns to digit 0, and
  // once right after reset so the display does not wait a whole frame.
  always_comb begin
    frame_val_d = frame_val_q;
    frame_dp_d  = frame_dp_q;
    load_d      = 1'b0;
    if (frame_wrap || load_q) begin
      frame_val_d = value;
      frame_dp_d  = dp_in;
    end
  end

  // Select the nibble and decimal point of the digit being scanned.
  always_comb begin
    cur_nibble = frame_val_q[3:0];
    cur_dp     = frame_dp_q[0];
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_q == DW'(k)) begin
        cur_nibble = frame_val_q[4*k +: 4];
        cur_dp     = frame_dp_q[k];
      end
    end
  end

  hex7_dec u_hex7_dec (
    .nibble (cur_nibble),
    .seg_n  (cur_seg)
  );

`ifdef SEG7_SCAN_LZB_EN
  logic [DIGITS-1:0] lz_mask;

  // Leading-zero mask: walk down from the top digit while nibbles stay
  // zero. Digit 0 is never masked so a zero value still shows "0"; a digit
  // with its decimal point requested is kept lit.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run & (frame_val_q[4*k +: 4] == 4'h0);
      lz_mask[k] = zero_run & ~frame_dp_q[k];
    end
  end
`endif

  // Next output values: one active-low anode, glyph and decimal point of
  // the current digit. blank only darkens the anodes; scanning continues.
  always_comb begin
    an_d = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (digit_q == DW'(k)) begin
        an_d[k] = 1'b0;
      end
    end
`ifdef SEG7_SCAN_LZB_EN
    an_d = an_d | lz_mask;
`endif
    if (blank) begin
      an_d = '1;
    end
    seg_d = cur_seg;
    dp_d  = ~cur_dp;
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q      <= 1'b0;
      scan_cnt_q  <= '0;
      digit_q     <= '0;
      frame_val_q <= '0;
      frame_dp_q  <= '0;
      load_q      <= 1'b1;
      an_q        <= '1;
      seg_q       <= SEG_OFF;
      dp_q        <= 1'b1;
    end else begin
      tick_q      <= tick_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_q     <= digit_d;
      frame_val_q <= frame_val_d;
      frame_dp_q  <= frame_dp_d;
      load_q      <= load_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan with DIGITS=4, SCAN_DIV=2 and tick_in toggling every
// two clk cycles. A slot-counting reference model predicts an/seg/dp every
// cycle; directed steps add fixed-value checks for the documented cases.
module tb_seg7_scan;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 2;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GF = 7'b0001110;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        tick_in = 1'b0;
  logic [15:0] value   = 16'h0000;
  logic [3:0]  dp_in   = 4'h0;
  logic        blank   = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks   = 0;
  int failures = 0;

  seg7_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk     (clk),
    .rst     (rst),
    .tick_in (tick_in),
    .value   (value),
    .dp_in   (dp_in),
    .blank   (blank),
    .an      (an),
    .seg     (seg),
    .dp      (dp)
  );

  // Clock and divider stand-in
  always #5 clk = ~clk;

  bit tick_run = 1'b1;
  int tick_div = 0;
  always @(negedge clk) begin
    if (tick_run) begin
      tick_div++;
      if (tick_div == 2) begin
        tick_div = 0;
        tick_in  = ~tick_in;
      end
    end
  end

  // Reference model: counts tick_in rising edges since reset; the digit is
  // the slot number modulo DIGITS and a new frame starts every
  // SCAN_DIV*DIGITS edges.
  int          m_edges = 0;
  bit          m_prev  = 1'b0;
  bit          m_load  = 1'b1;
  bit          m_wrap;
  int          m_d;
  logic [15:0] m_frame = 16'h0000;
  logic [3:0]  m_fdp   = 4'h0;
  logic [3:0]  m_an    = 4'hF;
  logic [6:0]  m_seg   = 7'h7F;
  logic        m_dp    = 1'b1;

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    logic [6:0] lit;
    case (n)
      4'h0: lit = 7'h3F; 4'h1: lit = 7'h06; 4'h2: lit = 7'h5B; 4'h3: lit = 7'h4F;
      4'h4: lit = 7'h66; 4'h5: lit = 7'h6D; 4'h6: lit = 7'h7D; 4'h7: lit = 7'h07;
      4'h8: lit = 7'h7F; 4'h9: lit = 7'h6F; 4'hA: lit = 7'h77; 4'hB: lit = 7'h7C;
      4'hC: lit = 7'h39; 4'hD: lit = 7'h5E; 4'hE: lit = 7'h79; default: lit = 7'h71;
    endcase
    return ~lit;
  endfunction

  function automatic int m_digit();
    return (m_edges / SCAN_DIV) % DIGITS;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_edges = 0;
      m_prev  = 1'b0;
      m_load  = 1'b1;
      m_frame = 16'h0000;
      m_fdp   = 4'h0;
      m_an    = 4'hF;
      m_seg   = 7'h7F;
      m_dp    = 1'b1;
    end else begin
      m_d = m_digit();
      m_an = 4'hF;
      m_an[m_d] = 1'b0;
`ifdef SEG7_SCAN_LZB_EN
      for (int k = 1; k < DIGITS; k++) begin
        if ((m_frame >> (4 * k)) == 16'h0000 && !m_fdp[k]) m_an[k] = 1'b1;
      end
`endif
      if (blank) m_an = 4'hF;
      m_seg = ref_seg(m_frame[4*m_d +: 4]);
      m_dp  = ~m_fdp[m_d];
      m_wrap = 1'b0;
      if (tick_in && !m_prev) begin
        m_edges++;
        if (m_edges % (SCAN_DIV * DIGITS) == 0) m_wrap = 1'b1;
      end
      if (m_wrap || m_load) begin
        m_frame = value;
        m_fdp   = dp_in;
      end
      m_load = 1'b0;
      m_prev = tick_in;
    end
  end

  // Checking helpers
  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("model", {an, seg, dp}, {m_an, m_seg, m_dp});
    end
  endtask

  task automatic wait_an(input string tag, input logic [3:0] target);
    int n;
    n = 0;
    while (an !== target && n < 64) begin
      step(1);
      n++;
    end
    chk({tag, "_reach"}, {8'h00, an}, {8'h00, target});
  endtask

  task automatic wait_model(input int dig, input int cnt);
    int n;
    n = 0;
    while (!(m_digit() == dig && (m_edges % SCAN_DIV) == cnt) && n < 64) begin
      step(1);
      n++;
    end
    chk("model_pos_reach", {11'h000, (m_digit() == dig && (m_edges % SCAN_DIV) == cnt)}, 12'h001);
  endtask

  initial begin
    // Reset and idle
    rst   = 1'b1;
    value = 16'h0000;
    step(5);
    chk("reset_state", {an, seg, dp}, 12'hFFF);
    rst = 1'b0;
    step(1);
    chk("first_out", {1'b0, an, seg}, {1'b0, 4'b1110, G0});

    // Scan order with 1A3F
    value = 16'h1A3F;
    step(40);
    wait_an("scan_d0", 4'b1110);
    chk("scan_seg_d0", {5'h00, seg}, {5'h00, GF});
    wait_an("scan_d1", 4'b1101);
    chk("scan_seg_d1", {5'h00, seg}, {5'h00, G3});
    wait_an("scan_d2", 4'b1011);
    chk("scan_seg_d2", {5'h00, seg}, {5'h00, GA});
    wait_an("scan_d3", 4'b0111);
    chk("scan_seg_d3", {5'h00, seg}, {5'h00, G1});
    wait_an("scan_wrap", 4'b1110);
    chk("scan_seg_wrap", {5'h00, seg}, {5'h00, GF});

    // Anti-tear: value changes while digit 2 is being scanned
    value = 16'h1234;
    step(40);
    wait_model(2, 0);
    value = 16'h5678;
    wait_an("tear_d2", 4'b1011);
    chk("tear_seg_d2", {5'h00, seg}, {5'h00, G2});
    wait_an("tear_d3", 4'b0111);
    chk("tear_seg_d3", {5'h00, seg}, {5'h00, G1});
    wait_an("tear_d0", 4'b1110);
    chk("tear_seg_d0", {5'h00, seg}, {5'h00, G8});

    // blank with a decimal point on digit 2
    dp_in = 4'b0100;
    step(40);
    blank = 1'b1;
    step(1);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("blank_an", {8'h00, an}, 12'h00F);
    end
    blank = 1'b0;
    wait_an("dp_d2", 4'b1011);
    chk("dp_on_d2", {11'h000, dp}, 12'h000);
    step(40);

    // Reset mid-scan at digit 3, scan count 1
    value = 16'hBEEF;
    wait_model(3, 1);
    rst = 1'b1;
    step(1);
    chk("midreset_an", {8'h00, an}, 12'h00F);
    step(1);
    rst = 1'b0;
    step(1);
    chk("restart_out", {1'b0, an, seg}, {1'b0, 4'b1110, G0});
    step(1);
    chk("reload_seg", {1'b0, an, seg}, {1'b0, 4'b1110, GF});
    step(40);

    // Randomized traffic, including stuck tick_in and short resets
    for (int i = 0; i < 30; i++) begin
      value    = 16'($urandom);
      dp_in    = 4'($urandom_range(0, 15));
      blank    = ($urandom_range(0, 3) == 0);
      tick_run = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        step($urandom_range(1, 3));
        rst = 1'b0;
      end
      step($urandom_range(4, 40));
    end
    tick_run = 1'b1;
    blank    = 1'b0;
    dp_in    = 4'h0;

    // Leading zeros
    value = 16'h0042;
    step(40);
    for (int i = 0; i < 40; i++) begin
      step(1);
`ifdef SEG7_SCAN_LZB_EN
      chk("lzb_upper_dark", {10'h000, an[3:2]}, 12'h003);
`endif
    end
    value = 16'h0000;
    step(40);
    wait_an("zero_d0", 4'b1110);
    chk("zero_seg", {5'h00, seg}, {5'h00, G0});
    step(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
